// File: rtl/chip_test_pkg.sv
// Shared types and constants for the chip test sequencer.
package chip_test_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_OUT,
    ST_LATCH,
    ST_SETTLE,
    ST_SHIFT_IN,
    ST_CHECK,
    ST_FINISH
  } seq_state_t;

  localparam logic [CNT_W-1:0] ERR_SAT   = 16'hFFFF;
  // Galois right-shift taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/chip_serial_shifter.sv
// Serial engine: divided sclk, MSB-first sdo on falling edges, sdi sampled on rising edges.
module chip_serial_shifter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  i_start,
  input  logic                  i_dir,
  input  logic                  i_clr,
  input  logic [DATA_WIDTH-1:0] i_tx_word,
  input  logic                  i_sdi,
  output logic                  o_sclk,
  output logic                  o_sdo,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rx_word
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

  logic                  r_active;
  logic                  r_dir;
  logic [DIV_W-1:0]      r_div;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_WIDTH-2:0] r_shift;
  logic [DATA_WIDTH-1:0] r_rx;
  logic                  r_sclk;
  logic                  r_sdo;
  logic                  r_done;

  // r_shift holds the bits still to be sent; the MSB goes straight to sdo at start
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_active <= 1'b0;
      r_dir    <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_rx     <= '0;
      r_sclk   <= 1'b0;
      r_sdo    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_clr) begin
        r_active <= 1'b0;
        r_sclk   <= 1'b0;
        r_sdo    <= 1'b0;
      end else if (i_start) begin
        r_active <= 1'b1;
        r_dir    <= i_dir;
        r_div    <= '0;
        r_bit    <= '0;
        r_sclk   <= 1'b0;
        r_shift  <= i_tx_word[DATA_WIDTH-2:0];
        r_sdo    <= i_dir ? 1'b0 : i_tx_word[DATA_WIDTH-1];
      end else if (r_active) begin
        if (r_div == DIV_W'(CLK_DIV - 1)) begin
          r_div <= '0;
          if (!r_sclk) begin
            r_sclk <= 1'b1;
            if (r_dir) r_rx <= {r_rx[DATA_WIDTH-2:0], i_sdi};
          end else begin
            r_sclk <= 1'b0;
            if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
              r_active <= 1'b0;
              r_done   <= 1'b1;
              r_sdo    <= 1'b0;
            end else begin
              r_bit   <= r_bit + BIT_W'(1);
              r_shift <= r_shift << 1;
              r_sdo   <= r_dir ? 1'b0 : r_shift[DATA_WIDTH-2];
            end
          end
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
    end
  end

  assign o_sclk    = r_sclk;
  assign o_sdo     = r_sdo;
  assign o_done    = r_done;
  assign o_rx_word = r_rx;

endmodule

// File: rtl/chip_test_sequencer.sv
// Stimulus/latch/settle/response/compare loop for the chip under test.
// Optional: CHIP_SEQ_LFSR_EN selects a Galois LFSR stimulus sequence instead of increment.
import chip_test_pkg::*;

module chip_test_sequencer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  ctrl_start,
  input  logic                  ctrl_abort,
  input  logic [DATA_WIDTH-1:0] cfg_pattern,
  input  logic [CNT_W-1:0]      cfg_iterations,
  input  logic [DATA_WIDTH-1:0] cfg_mask,
  output logic                  chip_sclk,
  output logic                  chip_sdo,
  input  logic                  chip_sdi,
  output logic                  chip_latch,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_W-1:0]      iter_count,
  output logic [CNT_W-1:0]      err_count,
  output logic [DATA_WIDTH-1:0] last_resp
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  seq_state_t            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_stim, r_mask, r_last_resp, w_seed, w_stim_nxt, w_rx_word;
  logic [CNT_W-1:0]      r_iter_cfg, r_iter_count, r_err_count;
  logic [SET_W-1:0]      r_settle;
  logic                  r_busy, r_done, r_aborted, r_abort_pend, r_latch;
  logic                  w_sh_start, w_sh_dir, w_sh_clr, w_sh_done;
  logic                  w_run_abort, w_last_iter, w_mismatch;

`ifdef CHIP_SEQ_LFSR_EN
  assign w_seed     = (cfg_pattern == '0) ? DATA_WIDTH'(1) : cfg_pattern;
  assign w_stim_nxt = r_stim[0] ? ((r_stim >> 1) ^ DATA_WIDTH'(LFSR_TAPS)) : (r_stim >> 1);
`else
  assign w_seed     = cfg_pattern;
  assign w_stim_nxt = r_stim + DATA_WIDTH'(1);
`endif

  // FINISH is terminal, so a held abort cannot keep the FSM spinning there
  assign w_run_abort = ctrl_abort && (r_state != ST_IDLE) && (r_state != ST_FINISH);
  assign w_last_iter = (r_iter_count + CNT_W'(1)) == r_iter_cfg;
  assign w_mismatch  = |((w_rx_word ^ r_stim) & r_mask);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_run_abort) begin
      w_state_nxt = ST_FINISH;
    end else begin
      case (r_state)
        ST_IDLE:      if (ctrl_start) w_state_nxt = ST_LOAD;
        ST_LOAD:      w_state_nxt = (r_iter_cfg == '0) ? ST_FINISH : ST_SHIFT_OUT;
        ST_SHIFT_OUT: if (w_sh_done) w_state_nxt = ST_LATCH;
        ST_LATCH:     w_state_nxt = ST_SETTLE;
        ST_SETTLE:    if (r_settle == SET_W'(SETTLE_CYCLES - 1)) w_state_nxt = ST_SHIFT_IN;
        ST_SHIFT_IN:  if (w_sh_done) w_state_nxt = ST_CHECK;
        ST_CHECK:     w_state_nxt = w_last_iter ? ST_FINISH : ST_LOAD;
        ST_FINISH:    w_state_nxt = ST_IDLE;
        default:      w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_sh_start = ((r_state == ST_LOAD)   && (w_state_nxt == ST_SHIFT_OUT)) ||
                      ((r_state == ST_SETTLE) && (w_state_nxt == ST_SHIFT_IN));
  assign w_sh_dir   = (r_state == ST_SETTLE);
  assign w_sh_clr   = w_run_abort;

  chip_serial_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLK_DIV    (CLK_DIV)
  ) u_shifter (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .i_start   (w_sh_start),
    .i_dir     (w_sh_dir),
    .i_clr     (w_sh_clr),
    .i_tx_word (r_stim),
    .i_sdi     (chip_sdi),
    .o_sclk    (chip_sclk),
    .o_sdo     (chip_sdo),
    .o_done    (w_sh_done),
    .o_rx_word (w_rx_word)
  );

  // Run configuration, counters and status flags
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_stim       <= '0;
      r_mask       <= '0;
      r_iter_cfg   <= '0;
      r_iter_count <= '0;
      r_err_count  <= '0;
      r_last_resp  <= '0;
      r_settle     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_latch      <= 1'b0;
    end else begin
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_latch  <= (w_state_nxt == ST_LATCH);
      r_settle <= (r_state == ST_SETTLE) ? r_settle + SET_W'(1) : '0;
      if (w_run_abort) r_abort_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (ctrl_start) begin
            r_stim       <= w_seed;
            r_mask       <= cfg_mask;
            r_iter_cfg   <= cfg_iterations;
            r_iter_count <= '0;
            r_err_count  <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (!w_run_abort) begin
            r_last_resp  <= w_rx_word;
            r_iter_count <= r_iter_count + CNT_W'(1);
            if (w_mismatch && (r_err_count != ERR_SAT)) r_err_count <= r_err_count + CNT_W'(1);
            if (!w_last_iter) r_stim <= w_stim_nxt;
          end
        end
        ST_FINISH: begin
          r_done    <= 1'b1;
          r_aborted <= r_abort_pend;
        end
        default: ;
      endcase
    end
  end

  assign chip_latch = r_latch;
  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign iter_count = r_iter_count;
  assign err_count  = r_err_count;
  assign last_resp  = r_last_resp;

endmodule
